// File: rtl/ser_par_conv_gen.sv
// Serial-to-parallel converter: packs LANES-bit beats into WORD_WIDTH-bit words
// with a one-word output holding register and valid/ready on both sides.
module ser_par_conv_gen #(
    parameter int WORD_WIDTH = 32,
    parameter int LANES      = 1,
    parameter int MSB_FIRST  = 0,
    parameter int WCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES-1:0]      din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  clear,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic [WCNT_WIDTH-1:0] word_cnt
);

    localparam int BEATS = WORD_WIDTH / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FULL
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [WORD_WIDTH-1:0] sreg;
    logic [WORD_WIDTH-1:0] shifted;
    logic [WORD_WIDTH-1:0] load_word;
    logic                  accept;
    logic                  last_beat;
    logic                  hold_free;
    logic                  drain;
    logic                  load;

    generate
        if (LANES == WORD_WIDTH) begin : g_single
            assign shifted = din;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign shifted = {sreg[WORD_WIDTH-LANES-1:0], din};
        end else begin : g_lsb
            assign shifted = {din, sreg[WORD_WIDTH-1:LANES]};
        end
    endgenerate

    assign drain     = dout_valid && dout_ready;
    assign hold_free = !dout_valid || dout_ready;
    assign accept    = din_valid && din_ready && !clear;
    assign last_beat = (cnt == LAST);
    // A completed word moves to the hold register from the final beat or from S_FULL
    assign load      = !clear && hold_free &&
                       ((state == S_FULL) || (accept && last_beat));
    assign load_word = (state == S_FULL) ? sreg : shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_FULL: begin
                    if (hold_free) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    if (accept) begin
                        if (!last_beat) begin
                            state_nxt = S_SHIFT;
                        end else if (hold_free) begin
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_FULL;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        din_ready = (state != S_FULL);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sreg       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            word_cnt   <= '0;
        end else begin
            if (clear || load) begin
                cnt  <= '0;
                sreg <= '0;
            end else if (accept) begin
                sreg <= shifted;
                cnt  <= last_beat ? '0 : cnt + CW'(1);
            end
            if (load) begin
                dout       <= load_word;
                dout_valid <= 1'b1;
            end else if (drain) begin
                dout_valid <= 1'b0;
            end
            if (drain) begin
                word_cnt <= word_cnt + WCNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ser_par_conv_gen.sv
// Directed bench for ser_par_conv_gen: scoreboard on the main instance plus
// side instances for MSB-first, 4-lane and single-beat/counter-wrap cases.
module tb_ser_par_conv_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        no_clear = 1'b0;

    logic        din, din_valid, din_ready, clear;
    logic [31:0] dout;
    logic        dout_valid, dout_ready, busy;
    logic [15:0] word_cnt;

    logic        m_din, m_din_valid, m_din_ready;
    logic [31:0] m_dout;
    logic        m_dout_valid, m_dout_ready, m_busy;
    logic [15:0] m_word_cnt;

    logic [3:0]  q_din;
    logic        q_din_valid, q_din_ready;
    logic [31:0] q_dout;
    logic        q_dout_valid, q_dout_ready, q_busy;
    logic [15:0] q_word_cnt;

    logic [7:0]  w_din;
    logic        w_din_valid, w_din_ready;
    logic [7:0]  w_dout;
    logic        w_dout_valid, w_dout_ready, w_busy;
    logic [2:0]  w_word_cnt;

    ser_par_conv_gen u_main (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .clear(clear), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
        .word_cnt(word_cnt)
    );

    ser_par_conv_gen #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(m_din), .din_valid(m_din_valid),
        .din_ready(m_din_ready), .clear(no_clear), .dout(m_dout),
        .dout_valid(m_dout_valid), .dout_ready(m_dout_ready), .busy(m_busy),
        .word_cnt(m_word_cnt)
    );

    ser_par_conv_gen #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .din(q_din), .din_valid(q_din_valid),
        .din_ready(q_din_ready), .clear(no_clear), .dout(q_dout),
        .dout_valid(q_dout_valid), .dout_ready(q_dout_ready), .busy(q_busy),
        .word_cnt(q_word_cnt)
    );

    ser_par_conv_gen #(.WORD_WIDTH(8), .LANES(8), .WCNT_WIDTH(3)) u_w (
        .clk(clk), .rst_n(rst_n), .din(w_din), .din_valid(w_din_valid),
        .din_ready(w_din_ready), .clear(no_clear), .dout(w_dout),
        .dout_valid(w_dout_valid), .dout_ready(w_dout_ready), .busy(w_busy),
        .word_cnt(w_word_cnt)
    );

    int passed = 0;
    int total = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_word(input logic [31:0] w, input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            din       = w[i];
            din_valid = 1'b1;
            guard     = 0;
            while (!din_ready && guard < 100) begin
                tick();
                guard++;
            end
            if (guard >= 100) begin
                total++;
                $error("FAIL din_ready_timeout observed=0 expected=1");
            end
            tick();
        end
        din_valid = 1'b0;
    endtask

    // Scoreboard: every main-instance output handshake pops one expected word
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $error("FAIL sb_empty observed=%0h expected=none", dout);
            end else begin
                chk("sb_word", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w, w1, w2, w3, w4, w5, w6, w7, w8;
        logic [7:0]  bv;

        din = 0; din_valid = 0; clear = 0; dout_ready = 1;
        m_din = 0; m_din_valid = 0; m_dout_ready = 1;
        q_din = 0; q_din_valid = 0; q_dout_ready = 0;
        w_din = 0; w_din_valid = 0; w_dout_ready = 1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_din_ready", din_ready, 1);
        rst_n = 1'b1;
        tick();

        // LSB-first, MSB-first and 4-lane streams of the same word
        w = 32'hA5A5_0F0F;
        exp_q.push_back(w);
        for (int i = 0; i < 32; i++) begin
            din = w[i]; din_valid = 1'b1;
            m_din = w[31-i]; m_din_valid = 1'b1;
            q_din_valid = (i < 8);
            if (i < 8) q_din = w[4*i +: 4];
            tick();
            if (i == 30) chk("t1_no_early_valid", dout_valid, 0);
            if (i == 7) begin
                chk("t2_l4_dout", q_dout, w);
                chk("t2_l4_valid", q_dout_valid, 1);
                chk("t2_l4_busy", q_busy, 0);
                chk("t2_l4_ready", q_din_ready, 1);
                chk("t2_l4_wcnt", q_word_cnt, 0);
            end
        end
        din_valid = 0; m_din_valid = 0; q_din_valid = 0;
        chk("t1_valid", dout_valid, 1);
        chk("t1_dout", dout, w);
        chk("t1_wcnt_pre", word_cnt, 0);
        chk("t2_msb_dout", m_dout, w);
        chk("t2_msb_valid", m_dout_valid, 1);
        chk("t2_msb_busy", m_busy, 0);
        chk("t2_msb_wcnt_pre", m_word_cnt, 0);
        tick();
        chk("t1_wcnt", word_cnt, 1);
        chk("t1_valid_fall", dout_valid, 0);
        chk("t1_busy", busy, 0);
        chk("t2_msb_wcnt", m_word_cnt, 1);
        chk("t2_msb_ready", m_din_ready, 1);

        // Back-pressure: second word waits in the shift register
        dout_ready = 0;
        w1 = 32'h1234_5678; w2 = 32'h9ABC_DEF0;
        exp_q.push_back(w1); exp_q.push_back(w2);
        feed_word(w1, 32);
        feed_word(w2, 32);
        chk("t3_full_ready", din_ready, 0);
        chk("t3_full_busy", busy, 1);
        chk("t3_held_word", dout, w1);
        din = 1'b1; din_valid = 1'b1;
        tick();
        chk("t3_stall_ready", din_ready, 0);
        chk("t3_held_stable", dout, w1);
        dout_ready = 1;
        tick();
        chk("t3_word2_dout", dout, w2);
        chk("t3_word2_valid", dout_valid, 1);
        chk("t3_ready_back", din_ready, 1);
        din_valid = 0;
        tick();
        chk("t3_wcnt", word_cnt, 3);
        chk("t3_idle", busy, 0);

        // Final beat coincides with handshake of the held word
        dout_ready = 0;
        w3 = 32'h0F1E_2D3C; w4 = 32'hC3B2_A190;
        exp_q.push_back(w3); exp_q.push_back(w4);
        feed_word(w3, 32);
        feed_word(w4, 31);
        din = w4[31]; din_valid = 1'b1; dout_ready = 1;
        tick();
        din_valid = 0;
        chk("t4_valid_kept", dout_valid, 1);
        chk("t4_dout", dout, w4);
        chk("t4_ready_kept", din_ready, 1);
        tick();
        chk("t4_wcnt", word_cnt, 5);

        // Clear flushes a partial word; the beat on the clear cycle is dropped
        feed_word(32'hFFFF_FFFF, 10);
        din = 1'b1; din_valid = 1'b1; clear = 1'b1;
        tick();
        clear = 0; din_valid = 0;
        chk("t5_clear_busy", busy, 0);
        w5 = 32'hFFFF_0000;
        exp_q.push_back(w5);
        feed_word(w5, 32);
        chk("t5_no_residue", dout, w5);
        tick();
        chk("t5_wcnt", word_cnt, 6);

        dout_ready = 0;
        w6 = 32'h5A5A_1234;
        exp_q.push_back(w6);
        feed_word(w6, 32);
        feed_word(32'hFFFF_FFFF, 5);
        clear = 1'b1;
        tick();
        clear = 0;
        chk("t5_held_valid", dout_valid, 1);
        chk("t5_held_dout", dout, w6);
        chk("t5_held_busy", busy, 0);
        dout_ready = 1;
        tick();
        chk("t5_wcnt2", word_cnt, 7);

        // Async reset with a held word and a partial word
        dout_ready = 0;
        w7 = 32'h1357_9BDF;
        feed_word(w7, 32);
        feed_word(32'h0, 7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", dout_valid, 0);
        chk("t6_rst_dout", dout, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_wcnt", word_cnt, 0);
        chk("t6_rst_ready", din_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_rel_ready", din_ready, 1);
        w8 = 32'h2468_ACE0;
        exp_q.push_back(w8);
        dout_ready = 1;
        feed_word(w8, 32);
        tick();
        chk("t6_post_wcnt", word_cnt, 1);

        // Single-beat words and 3-bit counter wrap
        chk("t7_ready", w_din_ready, 1);
        for (int k = 0; k < 7; k++) begin
            bv = 8'(k * 17 + 3);
            w_din = bv; w_din_valid = 1'b1;
            tick();
            chk("t7_dout", w_dout, bv);
        end
        w_din_valid = 0;
        chk("t7_wcnt6", w_word_cnt, 6);
        chk("t7_busy", w_busy, 0);
        tick();
        chk("t7_wcnt_max", w_word_cnt, 7);
        w_din = 8'h5C; w_din_valid = 1'b1;
        tick();
        w_din_valid = 0;
        chk("t7_last_dout", w_dout, 8'h5C);
        tick();
        chk("t7_wrap", w_word_cnt, 0);
        chk("t7_valid_fall", w_dout_valid, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
